div_seq_ctrl: RTL and testbench

- Handshaked front/back-end controller for the team's existing combinational 64/32 unsigned divider (div32).
- Accepts a 64-bit dividend and 32-bit divisor on a valid/ready interface, in unsigned or signed mode.
- Converts signed operands to magnitudes and detects divide-by-zero and quotient overflow before launch.
- Holds the registered magnitudes stable for a multicycle window, then captures, sign-corrects and presents q/r on a valid/ready output.

---
 rtl/div_pkg.sv | 18 +
 rtl/div32.sv | 19 +
 rtl/div_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_div_seq_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding, constants and sizing helper for div_seq_ctrl
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] Q_SAT       = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_QMAX = 32'h7FFF_FFFF;

  // Counter must hold 0..n-1; keep at least one bit so n=1 still elaborates.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div32.sv
// rtl/div32.sv - combinational 64/32 unsigned divider core, caller guarantees x[63:32] < d
module div32 (
  input  logic [63:0] x,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic [31:0] r
);

  // Quotient fits 32 bits because the controller screens x[63:32] >= d beforehand.
  always_comb begin
    q = 32'd0;
    r = 32'd0;
    if (d != 32'd0) begin
      q = 32'(x / {32'd0, d});
      r = 32'(x % {32'd0, d});
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - handshaked sign/exception front end and multicycle capture around div32
module div_seq_ctrl #(
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] x,
  input  logic [31:0] d,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        div_zero,
  output logic        overflow
);
  import div_pkg::*;

  localparam int CW = cnt_width(int'(MC_CYCLES));
  localparam logic [CW-1:0] CNT_LAST = CW'(MC_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   xm_q, xm_d;
  logic [31:0]   dm_q, dm_d;
  logic          sx_q, sx_d, sd_q, sd_d, sg_q, sg_d;
  logic [31:0]   q_q, q_d, r_q, r_d;
  logic          dz_q, dz_d, ov_q, ov_d;

  logic          x_neg, d_neg, neg_res, range_ov;
  logic [63:0]   xm_in;
  logic [31:0]   dm_in, qm, rm, q_fix, r_fix;

  // Magnitudes of the incoming operands; -2^63 and -2^31 map onto their unsigned bit patterns.
  always_comb begin
    x_neg = is_signed & x[63];
    d_neg = is_signed & d[31];
    xm_in = x_neg ? (~x + 64'd1) : x;
    dm_in = d_neg ? (~d + 32'd1) : d;
  end

  div32 u_div32 (
    .x (xm_q),
    .d (dm_q),
    .q (qm),
    .r (rm)
  );

  // Sign correction and signed range screen on the divider result; unsigned mode never saturates here.
  always_comb begin
    neg_res  = sx_q ^ sd_q;
    q_fix    = neg_res ? (~qm + 32'd1) : qm;
    r_fix    = sx_q ? (~rm + 32'd1) : rm;
    range_ov = sg_q & (neg_res ? (qm > (SIGNED_QMAX + 32'd1)) : (qm > SIGNED_QMAX));
  end

  // Next-state, operand latch and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xm_d    = xm_q;
    dm_d    = dm_q;
    sx_d    = sx_q;
    sd_d    = sd_q;
    sg_d    = sg_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          xm_d  = xm_in;
          dm_d  = dm_in;
          sx_d  = x_neg;
          sd_d  = d_neg;
          sg_d  = is_signed;
          cnt_d = '0;
          if (d == 32'd0) begin
            state_d = DONE;
            q_d     = Q_SAT;
            r_d     = x[31:0];
            dz_d    = 1'b1;
            ov_d    = 1'b0;
          end else if (xm_in[63:32] >= dm_in) begin
            state_d = DONE;
            q_d     = Q_SAT;
            r_d     = 32'd0;
            dz_d    = 1'b0;
            ov_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          dz_d    = 1'b0;
          if (range_ov) begin
            ov_d = 1'b1;
            q_d  = Q_SAT;
            r_d  = 32'd0;
          end else begin
            ov_d = 1'b0;
            q_d  = q_fix;
            r_d  = r_fix;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xm_q    <= 64'd0;
      dm_q    <= 32'd0;
      sx_q    <= 1'b0;
      sd_q    <= 1'b0;
      sg_q    <= 1'b0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xm_q    <= xm_d;
      dm_q    <= dm_d;
      sx_q    <= sx_d;
      sd_q    <= sd_d;
      sg_q    <= sg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - self-checking bench for div_seq_ctrl against an arithmetic reference
module tb_div_seq_ctrl;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] x_i = 64'd0;
  logic [31:0] d_i = 32'd0;
  logic        sgn = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] q_o, r_o;
  logic        dz_o, ov_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_q, last_r;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    logic [7:0]  lat;
  } res_t;

  div_seq_ctrl #(.MC_CYCLES(MC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x_i),
    .d         (d_i),
    .is_signed (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q_o),
    .r         (r_o),
    .div_zero  (dz_o),
    .overflow  (ov_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain truncating division on wide signed integers.
  function automatic res_t model(input logic [63:0] x, input logic [31:0] d, input logic s);
    res_t e;
    logic signed [65:0] xs, ds, xa, da, qs, rs, lo, hi;
    e.lat = 8'(MC + 1);
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    xs = s ? {{2{x[63]}}, x} : {2'b00, x};
    ds = s ? {{34{d[31]}}, d} : {34'd0, d};
    if (d == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = x[31:0]; e.dz = 1'b1; e.lat = 8'd1;
      return e;
    end
    xa = (xs < 0) ? -xs : xs;
    da = (ds < 0) ? -ds : ds;
    if ((xa / da) >= 66'sh1_0000_0000) begin
      e.q = 32'hFFFF_FFFF; e.r = 32'd0; e.ov = 1'b1; e.lat = 8'd1;
      return e;
    end
    qs = xs / ds;
    rs = xs % ds;
    lo = s ? -66'sd2147483648 : 66'sd0;
    hi = s ? 66'sd2147483647 : 66'sd4294967295;
    if (qs < lo || qs > hi) begin
      e.q = 32'hFFFF_FFFF; e.r = 32'd0; e.ov = 1'b1;
    end else begin
      e.q = qs[31:0]; e.r = rs[31:0];
    end
    return e;
  endfunction

  // Called just after a falling edge with the DUT idle.
  task automatic run_op(input logic [63:0] x, input logic [31:0] d, input logic s, input int stall);
    res_t e;
    int n;
    logic [31:0] hq, hr;
    e = model(x, d, s);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; x_i = x; d_i = d; sgn = s;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    in_valid = 1'b0;
    x_i = {$urandom, $urandom}; d_i = $urandom; sgn = 1'($urandom);
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(e.lat));
    chk("q", 64'(q_o), 64'(e.q));
    chk("r", 64'(r_o), 64'(e.r));
    chk("div_zero", 64'(dz_o), 64'(e.dz));
    chk("overflow", 64'(ov_o), 64'(e.ov));
    last_q = q_o; last_r = r_o;
    hq = q_o; hr = r_o;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; x_i = 64'd50; d_i = 32'd5; sgn = 1'b0;
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_q", 64'(q_o), 64'(hq));
      chk("stall_r", 64'(r_o), 64'(hr));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] rv;
    logic [63:0] rx;
    logic [31:0] rd;
    int cls;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_q", 64'(q_o), 64'd0);
    chk("rst_r", 64'(r_o), 64'd0);
    chk("rst_dz", 64'(dz_o), 64'd0);
    chk("rst_ov", 64'(ov_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(64'd100, 32'd7, 1'b0, 0);
    chk("u100_7_q", 64'(last_q), 64'd14);
    chk("u100_7_r", 64'(last_r), 64'd2);
    run_op(64'h0000_0000_1234_5678, 32'd0, 1'b0, 0);
    chk("dz_r", 64'(last_r), 64'h1234_5678);
    run_op(64'h0000_0001_0000_0000, 32'd1, 1'b0, 0);
    run_op(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    chk("umax_r", 64'(last_r), 64'hFFFF_FFFE);
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 1'b1, 0);
    chk("sm7_q", 64'(last_q), 64'hFFFF_FFFD);
    run_op(64'hFFFF_FFFF_8000_0000, 32'd1, 1'b1, 0);
    chk("smin_q", 64'(last_q), 64'h8000_0000);
    run_op(64'h0000_0000_8000_0000, 32'd1, 1'b1, 0);
    run_op(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(64'd1000, 32'd10, 1'b1, 5);

    // Reset asserted in the second CALC cycle.
    in_valid = 1'b1; x_i = 64'd1000; d_i = 32'd3; sgn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_q", 64'(q_o), 64'd0);
    chk("mid_rst_r", 64'(r_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(64'd9, 32'd3, 1'b0, 0);
    chk("post_rst_q", 64'(last_q), 64'd3);

    for (int k = 0; k < 40; k++) begin
      cls = int'($urandom_range(0, 4));
      rv = $urandom;
      rd = $urandom >> $urandom_range(0, 31);
      case (cls)
        0: rx = {{32{rv[31]}}, rv};
        1: rx = {$urandom, $urandom};
        2: begin rx = {$urandom, $urandom}; rd = 32'd0; end
        3: rx = {32'($urandom_range(0, 3)), rv};
        default: rx = {32'(rd >> 1), rv};
      endcase
      run_op(rx, rd, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
